// File: rtl/mux_7seg_scan_pkg.sv
// Shared digit-code and seven-segment constants for the frequency-indicator display path.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package mux_7seg_scan_pkg;

  localparam logic [3:0] CODE_DP    = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DP    = 8'h7F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode pattern for a scan position.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
// Codes 11..15 (and anything unlisted) render blank.
module seg7_decode
  import mux_7seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      CODE_DP: seg = SEG_DP;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mux_7seg_scan.sv
// Multiplexed 4-digit seven-segment driver with per-slot blanking and a
// frame-coherent input snapshot taken at the end of every full scan.
module mux_7seg_scan
  import mux_7seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] n_0f,
  input  logic [3:0] n_1f,
  input  logic [3:0] n_2f,
  input  logic [3:0] n_3f,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;
  logic [3:0]       snap_p0 [4];
  logic             slot_end_p0;
  logic             frame_end_p0;
  logic             blank_p0;
  logic [3:0]       code_p0;
  logic [7:0]       seg_dec_p0;

  assign slot_end_p0  = (cnt_p0 == CNT_LAST);
  assign frame_end_p0 = slot_end_p0 && (idx_p0 == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_p0 = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
      assign blank_p0 = (cnt_p0 < BLANK_END);
    end
  endgenerate

  assign code_p0 = snap_p0[idx_p0];

  seg7_decode u_dec (
    .code (code_p0),
    .seg  (seg_dec_p0)
  );

  // Stage p0: slot counter, scan index and frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      idx_p0     <= 2'd0;
      frame_tick <= 1'b0;
      for (int i = 0; i < 4; i++) snap_p0[i] <= CODE_BLANK;
    end else begin
      frame_tick <= frame_end_p0;
      if (slot_end_p0) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 2'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      // All four codes are captured on the same edge so a frame is never mixed.
      if (frame_end_p0) begin
        snap_p0[0] <= n_0f;
        snap_p0[1] <= n_1f;
        snap_p0[2] <= n_2f;
        snap_p0[3] <= n_3f;
      end
    end
  end

  // Stage p1: registered anode/segment drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else if (blank_p0) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_select(idx_p0);
      seg <= seg_dec_p0;
    end
  end

endmodule

// File: tb/tb_mux_7seg_scan.sv
// Directed bench for mux_7seg_scan: one instance with blanking, one without,
// driven by the same inputs and walked frame by frame against hand-computed tables.
module tb_mux_7seg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] n_0f, n_1f, n_2f, n_3f;
  logic [3:0] an, an_b;
  logic [7:0] seg, seg_b;
  logic       frame_tick, frame_tick_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .n_0f       (n_0f),
    .n_1f       (n_1f),
    .n_2f       (n_2f),
    .n_3f       (n_3f),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  mux_7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .n_0f       (n_0f),
    .n_1f       (n_1f),
    .n_2f       (n_2f),
    .n_3f       (n_3f),
    .an         (an_b),
    .seg        (seg_b),
    .frame_tick (frame_tick_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Input codes {n3,n2,n1,n0} presented during frame f; shown in frame f+1.
  logic [15:0] in_tab [8];
  // Expected segments {slot3,slot2,slot1,slot0} displayed in frame f.
  logic [31:0] exp_tab [8];

  initial begin
    in_tab[0] = 16'h1A52;  exp_tab[0] = 32'hFFFFFFFF;
    in_tab[1] = 16'h1A52;  exp_tab[1] = 32'hF97F92A4;
    in_tab[2] = 16'h1A52;  exp_tab[2] = 32'hF97F92A4;
    in_tab[3] = 16'h8A50;  exp_tab[3] = 32'h807F92C0;
    in_tab[4] = 16'hFEDC;  exp_tab[4] = 32'h807F92C0;
    in_tab[5] = 16'h7643;  exp_tab[5] = 32'hFFFFFFFF;
    in_tab[6] = 16'h901F;  exp_tab[6] = 32'hF88299B0;
    in_tab[7] = 16'h901F;  exp_tab[7] = 32'h90C0F9FF;
  end

  task automatic apply_inputs(input logic [15:0] v);
    n_3f = v[15:12];
    n_2f = v[11:8];
    n_1f = v[7:4];
    n_0f = v[3:0];
  endtask

  // Never more than one anode low, on either build.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot_a", 32'($countones(~an) <= 1), 32'd1);
      check("onehot_b", 32'($countones(~an_b) <= 1), 32'd1);
    end
  end

  task automatic run_frame(input int f);
    logic [31:0] ex;
    logic [7:0]  es;
    logic [3:0]  ea;
    int slot, pos;
    ex = exp_tab[f];
    for (int k = 1; k <= 4 * RD; k++) begin
      @(negedge clk);
      slot = (k - 1) / RD;
      pos  = (k - 1) % RD;
      es   = ex[slot*8 +: 8];
      ea   = ~(4'b0001 << slot);
      if (pos < BC) begin
        check($sformatf("f%0d_k%0d_an_blank", f, k), 32'(an), 32'hF);
        check($sformatf("f%0d_k%0d_seg_blank", f, k), 32'(seg), 32'hFF);
      end else begin
        check($sformatf("f%0d_k%0d_an", f, k), 32'(an), 32'(ea));
        check($sformatf("f%0d_k%0d_seg", f, k), 32'(seg), 32'(es));
      end
      check($sformatf("f%0d_k%0d_an_b", f, k), 32'(an_b), 32'(ea));
      check($sformatf("f%0d_k%0d_seg_b", f, k), 32'(seg_b), 32'(es));
      check($sformatf("f%0d_k%0d_tick", f, k), 32'(frame_tick), 32'(k == 4 * RD));
      check($sformatf("f%0d_k%0d_tick_b", f, k), 32'(frame_tick_b), 32'(k == 4 * RD));
      // Mid-slot-1 change: must not leak into the frame being shown.
      if (f == 2 && k == RD + 4) begin
        n_0f = 4'd0;
        n_3f = 4'd8;
      end
    end
    if (f < 7) apply_inputs(in_tab[f + 1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    apply_inputs(16'h1A52);
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_tick", 32'(frame_tick), 32'd0);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_async_an", 32'(an), 32'hE);
    check("pre_async_seg", 32'(seg), 32'hFF);

    // Reset asserted between edges must take effect without a clock.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'hFF);
    check("async_tick", 32'(frame_tick), 32'd0);
    check("async_an_b", 32'(an_b), 32'hF);

    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 8; f++) run_frame(f);

    // Walk to idx=2, cnt=5 and pulse reset for one cycle.
    repeat (21) @(negedge clk);
    check("mid_pre_an", 32'(an), 32'hB);
    check("mid_pre_an_b", 32'(an_b), 32'hB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    check("mid_rst_an_b", 32'(an_b), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= BC + 1; k++) begin
      @(negedge clk);
      check($sformatf("rel_k%0d_an", k), 32'(an), (k <= BC) ? 32'hF : 32'hE);
      check($sformatf("rel_k%0d_seg", k), 32'(seg), 32'hFF);
      check($sformatf("rel_k%0d_an_b", k), 32'(an_b), 32'hE);
      check($sformatf("rel_k%0d_seg_b", k), 32'(seg_b), 32'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
